// File: rtl/dmux8way_rr_scheduler.sv
// Round-robin scheduler sharing one DMux8Way lane among 8 requesters.
// Registered one-hot grant plus 3-bit select; each tenure is capped at HOLD_MAX cycles.
module dmux8way_rr_scheduler #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       preempt,
  output logic       state_o
);

  // Handshake: req[i] is a level request; the lane belongs to requester i
  // from the first cycle gnt[i] is high until the cycle it drops. There is
  // no ready/ack; a requester drops req[i] to release the lane early.

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       preempt_q, preempt_d;

  logic [2:0] arb_idle;
  logic [2:0] arb_next;
  logic [2:0] sel_plus1;
  logic       req_any;
  logic       tenure_end;

  // First set bit of r scanning start, start+1, ... with 3-bit wrap.
  function automatic logic [2:0] arb(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    arb   = start;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + i[2:0];
      if (!found && r[idx]) begin
        arb   = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign req_any    = |req;
  assign sel_plus1  = sel_q + 3'd1;
  assign arb_idle   = arb(req, ptr_q);
  assign arb_next   = arb(req, sel_plus1);
  assign tenure_end = !req[sel_q] || (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = GRANT;
          sel_d   = arb_idle;
          gnt_d   = 8'd1 << arb_idle;
          busy_d  = 1'b1;
          hold_d  = 4'd0;
        end
      end
      GRANT: begin
        if (!tenure_end) begin
          hold_d = hold_q + 4'd1;
        end else begin
          ptr_d     = sel_plus1;
          preempt_d = req[sel_q];
          hold_d    = 4'd0;
          if (req_any) begin
            // Back-to-back hand-off searches from the new pointer on this edge.
            sel_d = arb_next;
            gnt_d = 8'd1 << arb_next;
          end else begin
            state_d = IDLE;
            gnt_d   = 8'd0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      hold_q    <= 4'd0;
      gnt_q     <= 8'd0;
      sel_q     <= 3'd0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_dmux8way_rr_scheduler.sv
// Bench for dmux8way_rr_scheduler: directed scenarios plus random traffic,
// checked against a tenure-counting model for HOLD_MAX=4 and HOLD_MAX=1.
module tb_dmux8way_rr_scheduler;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt0, gnt1;
  logic [2:0] sel0, sel1;
  logic       busy0, busy1, pre0, pre1, st0, st1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [12:0] exp_q0[$];
  logic [12:0] exp_q1[$];

  // Reference model state, one slot per instance: owner is -1 when idle.
  int m_owner[2];
  int m_ten[2];
  int m_start[2];
  int m_last[2];
  bit m_pre[2];

  dmux8way_rr_scheduler #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt0), .sel(sel0),
    .busy(busy0), .preempt(pre0), .state_o(st0)
  );

  dmux8way_rr_scheduler #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt1), .sel(sel1),
    .busy(busy1), .preempt(pre1), .state_o(st1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pick(input logic [7:0] r, input int s);
    for (int i = 0; i < 8; i++)
      if (r[(s + i) % 8]) return (s + i) % 8;
    return -1;
  endfunction

  task automatic model_step(input int k, input int hold, input logic [7:0] r,
                            input logic rs, output logic [12:0] e);
    logic [7:0] g;
    if (rs) begin
      m_owner[k] = -1; m_ten[k] = 0; m_start[k] = 0; m_last[k] = 0; m_pre[k] = 0;
    end else if (m_owner[k] < 0) begin
      m_pre[k] = 0;
      if (r != 8'h00) begin
        m_owner[k] = pick(r, m_start[k]);
        m_ten[k]   = 1;
        m_last[k]  = m_owner[k];
      end
    end else if (r[m_owner[k]] && m_ten[k] < hold) begin
      m_ten[k] = m_ten[k] + 1;
      m_pre[k] = 0;
    end else begin
      m_pre[k]   = r[m_owner[k]];
      m_start[k] = (m_owner[k] + 1) % 8;
      if (r != 8'h00) begin
        m_owner[k] = pick(r, m_start[k]);
        m_ten[k]   = 1;
        m_last[k]  = m_owner[k];
      end else begin
        m_owner[k] = -1;
      end
    end
    g = (m_owner[k] < 0) ? 8'h00 : (8'h01 << m_owner[k]);
    e = {m_pre[k], (m_owner[k] >= 0), 3'(m_last[k]), g};
  endtask

  // Driver: inputs change on the falling edge, expectation for the next rising edge queued.
  task automatic drive(input logic [7:0] r, input logic rs, input int n);
    logic [12:0] e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      req   = r;
      reset = rs;
      model_step(0, 4, r, rs, e);
      exp_q0.push_back(e);
      model_step(1, 1, r, rs, e);
      exp_q1.push_back(e);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    logic [12:0] e;
    logic [12:0] a;
    #1;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = {pre0, busy0, sel0, gnt0};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL hold4 cyc %0d: got pre=%b busy=%b sel=%0d gnt=%h, expected pre=%b busy=%b sel=%0d gnt=%h",
                 cyc, a[12], a[11], a[10:8], a[7:0], e[12], e[11], e[10:8], e[7:0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a = {pre1, busy1, sel1, gnt1};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL hold1 cyc %0d: got pre=%b busy=%b sel=%0d gnt=%h, expected pre=%b busy=%b sel=%0d gnt=%h",
                 cyc, a[12], a[11], a[10:8], a[7:0], e[12], e[11], e[10:8], e[7:0]);
      end
    end
  end

  initial begin
    logic [7:0] r;
    int         len;
    req   = 8'h00;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_ten[k] = 0; m_start[k] = 0; m_last[k] = 0; m_pre[k] = 0;
    end

    // Reset holds everything low even with all requests high.
    drive(8'hFF, 1'b1, 2);
    drive(8'h00, 1'b0, 2);
    // Single request of 2 cycles, then release.
    drive(8'h10, 1'b0, 2);
    drive(8'h00, 1'b0, 3);
    // Lone persistent requester: continuous grant, periodic preempt.
    drive(8'h01, 1'b0, 13);
    drive(8'h00, 1'b0, 2);
    // All requesting: full rotation with no idle gaps.
    drive(8'h00, 1'b1, 1);
    drive(8'hFF, 1'b0, 36);
    drive(8'h00, 1'b0, 2);
    // Pointer wrap: grant 5, then 6 wins over 0.
    drive(8'h00, 1'b1, 1);
    drive(8'h20, 1'b0, 1);
    drive(8'h00, 1'b0, 2);
    drive(8'h41, 1'b0, 10);
    drive(8'h00, 1'b0, 2);
    // Reset in the middle of a grant to 3, then 3 again from ptr 0.
    drive(8'h08, 1'b0, 2);
    drive(8'h08, 1'b1, 1);
    drive(8'h00, 1'b0, 1);
    drive(8'h08, 1'b0, 3);
    // Non-selected bits toggling during a tenure.
    drive(8'h02, 1'b0, 1);
    drive(8'h06, 1'b0, 1);
    drive(8'h82, 1'b0, 1);
    drive(8'hA2, 1'b0, 3);
    drive(8'h00, 1'b0, 2);

    // Random traffic: requests held for random stretches, rare resets.
    for (int t = 0; t < 120; t++) begin
      r   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) r = 8'h00;
      if ($urandom_range(0, 4) == 0) r = 8'h01 << $urandom_range(0, 7);
      len = $urandom_range(1, 10);
      drive(r, ($urandom_range(0, 40) == 0), len);
    end

    drive(8'h00, 1'b0, 2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
